// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for the multicycle RV32I core. A Moore-style FSM sequences each
// instruction over 3-5 cycles through one shared memory port and one ALU.
// Supported instructions: lw, sw, R-type, addi-class, beq/bne and (optionally)
// jal. Unsupported opcodes go through a TRAP state that pulses illegal_instr.
//
// Parameters
//   ENABLE_JAL     decode jal (1101111); when 0 jal traps as illegal
//   ENABLE_BNE     branch funct3 001 is taken-on-not-zero; when 0 never taken
//   USE_MEM_READY  when 0, mem_ready is ignored and treated as 1
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   op, funct3,       instruction fields from the instruction register
//   funct7b5
//   zero              ALU zero flag
//   mem_ready         memory finished the current access this cycle
//   pc_write, adr_src, mem_write, ir_write, reg_write,
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control
//                     datapath controls (all combinational)
//   illegal_instr     one-cycle pulse in TRAP
//   state             current FSM state, exported for debug
//
// Memory handshake: an access started in FETCH, MEMREAD or MEMWRITE is held
// (state and all outputs unchanged) every cycle mem_ready is 0; the cycle in
// which mem_ready is 1 is the completing cycle, and the FSM advances on the
// following edge. Strobes tied to completion (ir_write, pc_write in FETCH)
// assert only in that completing cycle; mem_write stays high throughout.
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter bit ENABLE_JAL    = 1'b1,
    parameter bit ENABLE_BNE    = 1'b1,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t     state_q;
    state_t     state_d;
    logic       mem_rdy;
    logic [1:0] alu_op;
    logic       branch_taken;

    // Raw strobes before the reset override.
    logic       pc_write_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

    assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;
    assign state   = state_q;

    assign branch_taken = ((funct3 == 3'b000) & zero)
                        | (ENABLE_BNE & (funct3 == 3'b001) & ~zero);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BRANCH:    state_d = S_BRANCH;
                    OP_JAL:       state_d = ENABLE_JAL ? S_JAL : S_TRAP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;   // ALUWB writes the link address
            S_BRANCH:   state_d = S_FETCH;
            S_TRAP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;   // unused encodings recover
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        pc_write_raw  = 1'b0;
        adr_src       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC + 4 goes straight to the PC through the ALU result path.
                alu_src_a    = 2'b00;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                ir_write_raw = mem_rdy;
                pc_write_raw = mem_rdy;
            end
            S_DECODE: begin
                // Branch target (old PC + imm) lands in the ALU out register.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_JAL: begin
                // PC <- target computed in DECODE; ALU makes old PC + 4 for rd.
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = 2'b10;
                alu_op       = 2'b01;
                pc_write_raw = branch_taken;
            end
            S_TRAP: begin
                illegal_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset abandons the instruction without firing any write.
    assign pc_write      = pc_write_raw  & ~rst;
    assign mem_write     = mem_write_raw & ~rst;
    assign ir_write      = ir_write_raw  & ~rst;
    assign reg_write     = reg_write_raw & ~rst;
    assign illegal_instr = illegal_raw   & ~rst;

    // ------------------------------------------------------------ immediate sel
    always_comb begin
        case (op)
            OP_SW:     imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // -------------------------------------------------------------- ALU decoder
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b00: alu_control = 3'b000;
            2'b01: alu_control = 3'b001;
            default: begin
                case (funct3)
                    // Only R-type distinguishes sub; addi ignores bit 30.
                    3'b000:  alu_control = ((op == OP_RTYPE) & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
        endcase
    end

endmodule
